// File: rtl/nway_dp_bram_ctl_pkg.sv
// Shared types and helpers for the N-way dual-port memory controller.
package nway_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Default value the clear sequence writes into every entry
  localparam int unsigned INIT_VAL_DEFAULT = 0;

  // Address width with a floor of 1 so DEPTH=1 still yields a usable port
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nway_dp_bram_ctl_if.sv
// Access bus of the N-way dual-port memory: clear request, read and write
// ports, busy and read-valid status.
interface nway_dp_bram_ctl_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = nway_mem_pkg::addr_w(DEPTH);

  logic             clr;
  logic             busy;
  logic             re;
  logic [AW-1:0]    rad;
  logic [N-1:0]     we;
  logic [AW-1:0]    wad;
  logic [WIDTH-1:0] wdat;
  logic             rvalid;
  logic [WIDTH-1:0] rdat [N];

  modport master (output clr, re, rad, we, wad, wdat,
                  input  busy, rvalid, rdat);

  modport slave  (input  clr, re, rad, we, wad, wdat,
                  output busy, rvalid, rdat);

endinterface

// File: rtl/nway_dp_bram_ctl_bank.sv
// One way of the N-way memory: simple dual-port block RAM with one write
// port and one synchronous read port. The read register resets to zero.
module nway_mem_bank #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  // Write port; callers only enable it for in-range addresses
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read, read-first against a same-edge write; holds when idle
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nway_dp_bram_ctl.sv
// N-way dual-port memory for cache tag/data arrays. Reads all ways at rad,
// writes any subset of ways at wad, runs a hardware clear sequence after
// reset or on clr, tracks read validity and optionally registers outputs.
// Optional feature macro: NWAY_MEM_BYPASS_EN (write-first forwarding on a
// same-address read-during-write; read-first when undefined).
module nway_dp_bram_ctl
  import nway_mem_pkg::*;
#(
  parameter int unsigned      N        = 4,
  parameter int unsigned      WIDTH    = 18,
  parameter int unsigned      DEPTH    = 32,
  parameter int unsigned      OUT_REG  = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT_VAL_DEFAULT)
) (
  input logic               clk,
  input logic               rst,
  nway_dp_bram_ctl_if.slave bus
);

  localparam int unsigned   AW   = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          busy;
  logic          rd_acc;
  logic          rad_ok;
  logic          wad_ok;

  logic [N-1:0]     bwe;
  logic [AW-1:0]    bwad;
  logic [WIDTH-1:0] bwdat;
  logic             bre;
  logic [WIDTH-1:0] bq [N];

  logic             v1;
  logic             oor_q;
  logic [WIDTH-1:0] s1 [N];

  // FSM state and clear counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Clear sequencing: walk every address once, then idle until clr
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;
  assign rd_acc   = (state == IDLE) && bus.re;
  assign rad_ok   = (32'(bus.rad) < DEPTH);
  assign wad_ok   = (32'(bus.wad) < DEPTH);
  assign bre      = rd_acc && rad_ok;

  // Clear mux: the sequencer owns every write port while busy
  always_comb begin
    bwe   = '0;
    bwad  = bus.wad;
    bwdat = bus.wdat;
    if (busy) begin
      bwe   = rst ? '0 : '1;
      bwad  = cnt;
      bwdat = INIT_VAL;
    end else if (wad_ok) begin
      bwe = bus.we;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_way
    nway_mem_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bwe[g]),
      .waddr (bwad),
      .wdata (bwdat),
      .re    (bre),
      .raddr (bus.rad),
      .rdata (bq[g])
    );
  end

  // Read-stage tracking; flags update only on accepted reads so rdat holds
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) oor_q <= !rad_ok;
    end
  end

`ifdef NWAY_MEM_BYPASS_EN
  logic [N-1:0]     fwd_q;
  logic [WIDTH-1:0] fwd_dat;

  // Capture same-address write hits alongside the read
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q   <= '0;
      fwd_dat <= '0;
    end else if (rd_acc) begin
      fwd_q   <= ((bus.rad == bus.wad) && wad_ok) ? bus.we : '0;
      fwd_dat <= bus.wdat;
    end
  end
`endif

  // Read-stage data: out-of-range beats forwarding beats stored data
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      s1[i] = bq[i];
`ifdef NWAY_MEM_BYPASS_EN
      if (fwd_q[i]) s1[i] = fwd_dat;
`endif
      if (oor_q) s1[i] = INIT_VAL;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic             v2;
    logic [WIDTH-1:0] s2 [N];

    // Optional output register stage; holds when no read completes
    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        for (int unsigned i = 0; i < N; i++) s2[i] <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          for (int unsigned i = 0; i < N; i++) s2[i] <= s1[i];
        end
      end
    end

    assign bus.rvalid = v2;
    assign bus.rdat   = s2;
  end else begin : g_noreg
    assign bus.rvalid = v1;
    assign bus.rdat   = s1;
  end

endmodule

// File: tb/tb_nway_dp_bram_ctl.sv
// Directed bench for nway_dp_bram_ctl: three instances share stimulus
// (DEPTH=32 OUT_REG=0, DEPTH=32 OUT_REG=1, DEPTH=20 OUT_REG=0), INIT_VAL=3.
module tb_nway_dp_bram_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        re;
  logic [4:0]  rad;
  logic [3:0]  we;
  logic [4:0]  wad;
  logic [17:0] wdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nway_dp_bram_ctl_if #(.N(4), .WIDTH(18), .DEPTH(32)) i0 ();
  nway_dp_bram_ctl_if #(.N(4), .WIDTH(18), .DEPTH(32)) i1 ();
  nway_dp_bram_ctl_if #(.N(4), .WIDTH(18), .DEPTH(20)) i2 ();

  assign i0.clr = clr;  assign i0.re = re;  assign i0.rad = rad;
  assign i0.we  = we;   assign i0.wad = wad; assign i0.wdat = wdat;
  assign i1.clr = clr;  assign i1.re = re;  assign i1.rad = rad;
  assign i1.we  = we;   assign i1.wad = wad; assign i1.wdat = wdat;
  assign i2.clr = clr;  assign i2.re = re;  assign i2.rad = rad;
  assign i2.we  = we;   assign i2.wad = wad; assign i2.wdat = wdat;

  nway_dp_bram_ctl #(.N(4), .WIDTH(18), .DEPTH(32), .OUT_REG(0), .INIT_VAL(18'h3))
    dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  nway_dp_bram_ctl #(.N(4), .WIDTH(18), .DEPTH(32), .OUT_REG(1), .INIT_VAL(18'h3))
    dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  nway_dp_bram_ctl #(.N(4), .WIDTH(18), .DEPTH(20), .OUT_REG(0), .INIT_VAL(18'h3))
    dut2 (.clk(clk), .rst(rst), .bus(i2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n0 = 0, n1 = 0, n2 = 0;
    rst = 1'b1; clr = 1'b0; re = 1'b0; rad = '0; we = '0; wad = '0; wdat = '0;
    repeat (3) tick();
    checks++;
    if (i0.busy !== 1'b1 || i0.rvalid !== 1'b0 || i0.rdat[0] !== 18'h0 || i0.rdat[3] !== 18'h0) begin
      errors++;
      $display("FAIL reset_during: busy=%b rvalid=%b rdat0=%h rdat3=%h, want 1 0 0 0",
               i0.busy, i0.rvalid, i0.rdat[0], i0.rdat[3]);
    end
    rst = 1'b0;
    checks++;
    if (i1.busy !== 1'b1 || i1.rvalid !== 1'b0 || i1.rdat[1] !== 18'h0) begin
      errors++;
      $display("FAIL reset_after: busy=%b rvalid=%b rdat1=%h, want 1 0 0",
               i1.busy, i1.rvalid, i1.rdat[1]);
    end
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (!i0.busy && n0 == 0) n0 = n;
      if (!i1.busy && n1 == 0) n1 = n;
      if (!i2.busy && n2 == 0) n2 = n;
    end
    checks++;
    if (n0 !== 32) begin errors++; $display("FAIL clear_len_d32: got %0d want 32", n0); end
    checks++;
    if (n1 !== 32) begin errors++; $display("FAIL clear_len_oreg: got %0d want 32", n1); end
    checks++;
    if (n2 !== 20) begin errors++; $display("FAIL clear_len_d20: got %0d want 20", n2); end
    for (int a = 0; a < 32; a++) begin
      rad = 5'(a); re = 1'b1;
      tick();
      checks++;
      if (i0.rvalid !== 1'b1 || i0.rdat[0] !== 18'h3 || i0.rdat[1] !== 18'h3 ||
          i0.rdat[2] !== 18'h3 || i0.rdat[3] !== 18'h3) begin
        errors++;
        $display("FAIL clear_read a=%0d: rvalid=%b rdat=%h %h %h %h, want 1 and all 3",
                 a, i0.rvalid, i0.rdat[0], i0.rdat[1], i0.rdat[2], i0.rdat[3]);
      end
    end
    re = 1'b0;
    tick();
  endtask

  task automatic test_multi_write();
    logic [17:0] exp [4];
    exp = '{18'h1ABC, 18'h3, 18'h1ABC, 18'h3};
    we = 4'b0101; wad = 5'd5; wdat = 18'h1ABC;
    tick();
    we = '0; re = 1'b1; rad = 5'd5;
    tick();
    checks++;
    if (i0.rvalid !== 1'b1) begin errors++; $display("FAIL multi_rvalid: got %b want 1", i0.rvalid); end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (i0.rdat[w] !== exp[w]) begin
        errors++;
        $display("FAIL multi_rdat way%0d: got %h want %h", w, i0.rdat[w], exp[w]);
      end
    end
    re = 1'b0;
    tick();
    checks++;
    if (i0.rvalid !== 1'b0 || i0.rdat[0] !== 18'h1ABC || i0.rdat[1] !== 18'h3) begin
      errors++;
      $display("FAIL hold: rvalid=%b rdat0=%h rdat1=%h, want 0 1abc 3",
               i0.rvalid, i0.rdat[0], i0.rdat[1]);
    end
  endtask

  task automatic test_rdw();
    logic [17:0] exp0;
`ifdef NWAY_MEM_BYPASS_EN
    exp0 = 18'h2222;
`else
    exp0 = 18'h1111;
`endif
    we = 4'b0001; wad = 5'd9; wdat = 18'h1111;
    tick();
    re = 1'b1; rad = 5'd9; we = 4'b0001; wad = 5'd9; wdat = 18'h2222;
    tick();
    we = '0; re = 1'b0;
    checks++;
    if (i0.rvalid !== 1'b1 || i0.rdat[0] !== exp0) begin
      errors++;
      $display("FAIL rdw_way0: rvalid=%b rdat0=%h, want 1 %h", i0.rvalid, i0.rdat[0], exp0);
    end
    checks++;
    if (i0.rdat[1] !== 18'h3) begin errors++; $display("FAIL rdw_way1: got %h want 3", i0.rdat[1]); end
    re = 1'b1; rad = 5'd9;
    tick();
    re = 1'b0;
    checks++;
    if (i0.rdat[0] !== 18'h2222) begin errors++; $display("FAIL rdw_after: got %h want 2222", i0.rdat[0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp [3];
    exp = '{18'h101, 18'h202, 18'h303};
    we = 4'b1111;
    for (int a = 1; a <= 3; a++) begin
      wad = 5'(a); wdat = exp[a-1];
      tick();
    end
    we = '0;
    re = 1'b1; rad = 5'd1;
    tick();
    checks++;
    if (i1.rvalid !== 1'b0) begin errors++; $display("FAIL oreg_lat: rvalid=%b want 0", i1.rvalid); end
    rad = 5'd2;
    tick();
    checks++;
    if (i1.rvalid !== 1'b1 || i1.rdat[0] !== exp[0] || i1.rdat[3] !== exp[0]) begin
      errors++;
      $display("FAIL oreg_b2b0: rvalid=%b rdat0=%h rdat3=%h want 1 %h", i1.rvalid, i1.rdat[0], i1.rdat[3], exp[0]);
    end
    rad = 5'd3;
    tick();
    checks++;
    if (i1.rvalid !== 1'b1 || i1.rdat[2] !== exp[1]) begin
      errors++;
      $display("FAIL oreg_b2b1: rvalid=%b rdat2=%h want 1 %h", i1.rvalid, i1.rdat[2], exp[1]);
    end
    re = 1'b0;
    tick();
    checks++;
    if (i1.rvalid !== 1'b1 || i1.rdat[1] !== exp[2]) begin
      errors++;
      $display("FAIL oreg_b2b2: rvalid=%b rdat1=%h want 1 %h", i1.rvalid, i1.rdat[1], exp[2]);
    end
    tick();
    checks++;
    if (i1.rvalid !== 1'b0 || i1.rdat[1] !== exp[2]) begin
      errors++;
      $display("FAIL oreg_end: rvalid=%b rdat1=%h want 0 %h", i1.rvalid, i1.rdat[1], exp[2]);
    end
  endtask

  task automatic test_out_of_range();
    logic [17:0] exp [4];
    exp = '{18'h1ABC, 18'h3, 18'h1ABC, 18'h3};
    we = 4'b1111; wad = 5'd25; wdat = 18'h15555;
    tick();
    we = '0; re = 1'b1; rad = 5'd25;
    tick();
    checks++;
    if (i2.rvalid !== 1'b1 || i2.rdat[0] !== 18'h3 || i2.rdat[1] !== 18'h3 ||
        i2.rdat[2] !== 18'h3 || i2.rdat[3] !== 18'h3) begin
      errors++;
      $display("FAIL oor_read: rvalid=%b rdat=%h %h %h %h, want 1 and all 3",
               i2.rvalid, i2.rdat[0], i2.rdat[1], i2.rdat[2], i2.rdat[3]);
    end
    checks++;
    if (i0.rdat[0] !== 18'h15555) begin errors++; $display("FAIL inrange_25: got %h want 15555", i0.rdat[0]); end
    rad = 5'd5;
    tick();
    re = 1'b0;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (i2.rdat[w] !== exp[w]) begin
        errors++;
        $display("FAIL oor_entry5 way%0d: got %h want %h", w, i2.rdat[w], exp[w]);
      end
    end
    tick();
  endtask

  task automatic test_mid_clear();
    int h0 = 0, h1 = 0, h2 = 0, n0 = 0, n2 = 0, rv_bad = 0;
    // clr together with a read: read completes, clear starts
    clr = 1'b1; re = 1'b1; rad = 5'd5;
    tick();
    clr = 1'b0; re = 1'b0;
    checks++;
    if (i0.busy !== 1'b1 || i0.rvalid !== 1'b1 || i0.rdat[0] !== 18'h1ABC) begin
      errors++;
      $display("FAIL clr_with_read: busy=%b rvalid=%b rdat0=%h, want 1 1 1abc",
               i0.busy, i0.rvalid, i0.rdat[0]);
    end
    for (int i = 0; i < 60; i++) begin
      if (i0.busy) h0++;
      if (i1.busy) h1++;
      if (i2.busy) h2++;
      clr = (i == 5);
      tick();
    end
    clr = 1'b0;
    checks++;
    if (h0 !== 32 || h1 !== 32) begin errors++; $display("FAIL clr_ignored: busy cycles %0d/%0d want 32", h0, h1); end
    checks++;
    if (h2 !== 20) begin errors++; $display("FAIL clr_len_d20: busy cycles %0d want 20", h2); end
    re = 1'b1; rad = 5'd5;
    tick();
    re = 1'b0;
    checks++;
    if (i0.rdat[0] !== 18'h3 || i0.rdat[2] !== 18'h3) begin
      errors++;
      $display("FAIL recleared: rdat0=%h rdat2=%h want 3 3", i0.rdat[0], i0.rdat[2]);
    end
    // reset at counter=10 while accesses are presented
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    rst = 1'b1; re = 1'b1; rad = 5'd31; we = 4'b1111; wad = 5'd31; wdat = 18'h3FFFF;
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (i0.rvalid) rv_bad++;
      if (!i2.busy && n2 == 0) n2 = n;
      if (!i0.busy) begin
        n0 = n;
        break;
      end
    end
    re = 1'b0; we = '0;
    checks++;
    if (n0 !== 32) begin errors++; $display("FAIL rst_restart_d32: got %0d want 32", n0); end
    checks++;
    if (n2 !== 20) begin errors++; $display("FAIL rst_restart_d20: got %0d want 20", n2); end
    checks++;
    if (rv_bad !== 0) begin errors++; $display("FAIL busy_read_ignored: rvalid cycles %0d want 0", rv_bad); end
    tick();
    re = 1'b1; rad = 5'd31;
    tick();
    re = 1'b0;
    checks++;
    if (i0.rvalid !== 1'b1 || i0.rdat[3] !== 18'h3) begin
      errors++;
      $display("FAIL busy_write_ignored: rvalid=%b rdat3=%h want 1 3", i0.rvalid, i0.rdat[3]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_multi_write();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/nway_dp_bram_ctl.md
# nway_dp_bram_ctl

Parametrised N-way dual-port memory for the MRU cache tag/data arrays, successor to the plain N-way dual-port array. Every cycle it reads all N ways at one address and writes any subset of ways at another. It adds a hardware clear sequencer, read-valid tracking, an optional output register stage, and optional read-during-write forwarding. It sits between the cache lookup pipeline and the way-select/replacement logic.

## Interface
- N, 4: number of ways (1..16).
- WIDTH, 18: bits per way entry.
- DEPTH, 32: entries per way; need not be a power of 2.
- OUT_REG, 0: 1 adds one output register stage, so read latency becomes 2.
- INIT_VAL, 0: WIDTH-bit value written to every entry by the clear sequence.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  one-cycle pulse that requests a full clear.
- busy  out  1  high while the clear sequence runs; accesses are ignored.
- re  in  1  read enable.
- rad  in  $clog2(DEPTH)  read address.
- we  in  N  per-way write enables.
- wad  in  $clog2(DEPTH)  write address.
- wdat  in  WIDTH  write data, common to all enabled ways.
- rvalid  out  1  rdat is valid this cycle.
- rdat  out  WIDTH x N (unpacked [N])  read data, one entry per way.

## Operation
- FSM states: CLEAR and IDLE.
  - rst forces CLEAR with clear counter = 0.
  - In CLEAR, each cycle writes INIT_VAL to address counter in every way, then increments the counter.
  - When counter = DEPTH-1, that write completes and the FSM moves to IDLE.
  - In IDLE, clr=1 moves the FSM to CLEAR with counter = 0.
- busy = 1 exactly in CLEAR.
- While busy, re and we are ignored, and no new rvalid is generated.
- clr received while in CLEAR is ignored; the sequence does not restart.
- rst asserted during CLEAR restarts the sequence at address 0.
- clr in IDLE in the same cycle as re/we: that cycle's access is accepted, and CLEAR begins the next cycle.
- A read accepted before CLEAR begins still completes and delivers its rvalid.
- Writes: each way i with we[i]=1 stores wdat at wad. Multiple ways may be written in one cycle.
- Out-of-range addresses (value ≥ DEPTH):
  - The write is dropped.
  - The read returns INIT_VAL in all ways, with rvalid still asserted.
- Read-during-write at the same address (rad == wad, re=1, we[i]=1): the result for way i depends on NWAY_MEM_BYPASS_EN (see Configuration). Ways with we[i]=0 always return stored data.
- rdat holds its last value when rvalid=0.

## Timing
- During rst and on the first cycle after: busy=1, rvalid=0, rdat all ways = 0.
- Clear duration: the first cycle with rst=0 writes address 0; busy falls after DEPTH cycles. Example: DEPTH=32 gives busy low on cycle 32 after rst deasserts.
- Read latency with OUT_REG=0:
  - re sampled at edge k.
  - rvalid=1 and rdat valid after edge k+1.
- Read latency with OUT_REG=1: one cycle later, after edge k+2.
- Throughput: one read and one write per cycle, with no back-pressure.
- A write at edge k is visible to a non-forwarded read issued at edge k+1.
- rvalid follows re (when not busy) with a fixed delay; consecutive reads give consecutive rvalid pulses.

## Configuration
- NWAY_MEM_BYPASS_EN defined:
  - Read-during-write to the same address returns the new wdat for each written way (write-first).
  - Forwarding is applied in the read stage, before the optional OUT_REG stage.
- NWAY_MEM_BYPASS_EN undefined:
  - Returns the old stored contents (read-first).
  - No comparator logic is generated.

## Structure
- Package nway_mem_pkg holds:
  - the FSM state enum (CLEAR and IDLE);
  - the address-width helper function, $clog2 with a floor of 1;
  - the default INIT_VAL constant.
- Sub-module nway_mem_bank: one way.
  - Simple dual-port block RAM with one write port and one synchronous read port.
  - Carries a block-RAM style attribute.
  - Instantiated N times in a generate loop.
  - The clear mux (counter/INIT_VAL vs wad/wdat) lives in the top level.

## Test plan
- Reset clear: N=4, DEPTH=32, INIT_VAL=18'h3 → busy high for 32 cycles after rst falls; then reads of addresses 0..31 return 18'h3 in all 4 ways.
- Multi-way write/read: we=4'b0101, wad=5, wdat=18'h1ABC; then re at rad=5 → rvalid one cycle later, with rdat[0]=rdat[2]=18'h1ABC and rdat[1]=rdat[3]=18'h3.
- Read-during-write: rad=wad=9, we=4'b0001, wdat=18'h2222, old value 18'h1111 → rdat[0]=18'h2222 with NWAY_MEM_BYPASS_EN, 18'h1111 without.
- OUT_REG=1 back-to-back reads of addresses 1, 2, 3 → rvalid high for 3 consecutive cycles starting 2 cycles after the first re, with data in order.
- Mid-clear events:
  - clr pulse during CLEAR → ignored; busy stays high for exactly DEPTH cycles total.
  - rst at counter=10 → restart; busy low DEPTH cycles after rst falls.
- DEPTH=20, write at wad=25 → dropped; read at rad=25 returns INIT_VAL with rvalid=1; entry 5 is unchanged.
